// File: rtl/frame_pack_tx.sv
// frame_pack_tx: drains 32-bit words from an upstream FIFO and serializes them
// into a big-endian byte stream with SOF/EOF framing toward the MAC TX side.
// The frame length comes from a per-frame descriptor handshake (iLen/iLenVld).
// Optional build macro PAD_MIN_FRAME_EN: frames shorter than MIN_FRAME bytes
// are padded with 0x00 bytes up to MIN_FRAME bytes; otherwise they go as-is.
module frame_pack_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int MIN_FRAME  = 60
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [LEN_WIDTH-1:0]  iLen,
  input  logic                  iLenVld,
  output logic                  oLenRdy,
  output logic                  oLenErr,
  input  logic [DATA_WIDTH-1:0] iFifoData,
  input  logic                  iFifoEmpty,
  output logic                  oFifoREn,
  output logic [7:0]            oTxData,
  output logic                  oTxVld,
  output logic                  oTxSof,
  output logic                  oTxEof,
  input  logic                  iTxRdy,
  output logic                  oUnderrun,
  output logic                  oBusy
);

`ifdef PAD_MIN_FRAME_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_PAD} state_t;
  localparam logic [LEN_WIDTH-1:0] MIN_LEN_M1 = LEN_WIDTH'(MIN_FRAME - 1);
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;
`endif

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;        // data bytes still to send
  logic [1:0]            idx_q, idx_d;        // byte index inside word_q
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  first_q, first_d;    // no byte of this frame sent yet
  logic                  waited_q, waited_d;  // underrun already flagged for this wait
  logic                  len_err_q, len_err_d;
  logic                  underrun_q, underrun_d;
  logic                  fifo_ren;
  logic                  last_byte;
  logic [7:0]            cur_byte;

`ifdef PAD_MIN_FRAME_EN
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;        // bytes of this frame already sent
  logic                  pad_need;
  assign pad_need = (cnt_q < MIN_LEN_M1);
`else
  logic                  unused_min_frame;
  assign unused_min_frame = (MIN_FRAME > 0);
`endif

  assign last_byte = (rem_q == LEN_WIDTH'(1));

  // Select the current byte, most significant byte of the word first
  always_comb begin
    cur_byte = 8'h00;
    case (idx_q)
      2'd0: cur_byte = word_q[DATA_WIDTH-1  -: 8];
      2'd1: cur_byte = word_q[DATA_WIDTH-9  -: 8];
      2'd2: cur_byte = word_q[DATA_WIDTH-17 -: 8];
      2'd3: cur_byte = word_q[DATA_WIDTH-25 -: 8];
      default: cur_byte = 8'h00;
    endcase
  end

  // Next-state logic: descriptor accept, FIFO fetch, byte send and padding
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    word_d     = word_q;
    first_d    = first_q;
    waited_d   = waited_q;
    len_err_d  = 1'b0;
    underrun_d = 1'b0;
    fifo_ren   = 1'b0;
`ifdef PAD_MIN_FRAME_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iLenVld) begin
          if (iLen == '0) begin
            len_err_d = 1'b1;
          end else begin
            rem_d    = iLen;
            first_d  = 1'b1;
            waited_d = 1'b0;
            state_d  = S_FETCH;
`ifdef PAD_MIN_FRAME_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      S_FETCH: begin
        if (!iFifoEmpty) begin
          fifo_ren = 1'b1;
          word_d   = iFifoData;
          idx_d    = 2'd0;
          waited_d = 1'b0;
          state_d  = S_SEND;
        end else if (!first_q && !waited_q) begin
          // Mid-frame starvation: flag once per wait, not every cycle
          underrun_d = 1'b1;
          waited_d   = 1'b1;
        end
      end
      S_SEND: begin
        if (iTxRdy) begin
          rem_d   = rem_q - LEN_WIDTH'(1);
          idx_d   = idx_q + 2'd1;
          first_d = 1'b0;
`ifdef PAD_MIN_FRAME_EN
          cnt_d   = cnt_q + LEN_WIDTH'(1);
`endif
          if (last_byte) begin
            // Remaining bytes of the final word are dropped here
`ifdef PAD_MIN_FRAME_EN
            state_d = pad_need ? S_PAD : S_IDLE;
`else
            state_d = S_IDLE;
`endif
          end else if (idx_q == 2'd3) begin
            // Chain straight into the next word to keep 1 byte/cycle
            if (!iFifoEmpty) begin
              fifo_ren = 1'b1;
              word_d   = iFifoData;
            end else begin
              state_d  = S_FETCH;
            end
          end
        end
      end
`ifdef PAD_MIN_FRAME_EN
      S_PAD: begin
        if (iTxRdy) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (cnt_q == MIN_LEN_M1) state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset truncates any frame in flight
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      idx_q      <= 2'd0;
      word_q     <= '0;
      first_q    <= 1'b0;
      waited_q   <= 1'b0;
      len_err_q  <= 1'b0;
      underrun_q <= 1'b0;
`ifdef PAD_MIN_FRAME_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      first_q    <= first_d;
      waited_q   <= waited_d;
      len_err_q  <= len_err_d;
      underrun_q <= underrun_d;
`ifdef PAD_MIN_FRAME_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign oLenRdy   = (state_q == S_IDLE);
  assign oLenErr   = len_err_q;
  assign oUnderrun = underrun_q;
  assign oBusy     = (state_q != S_IDLE);
  assign oFifoREn  = fifo_ren;
  assign oTxSof    = (state_q == S_SEND) && first_q;
  assign oTxData   = (state_q == S_SEND) ? cur_byte : 8'h00;
`ifdef PAD_MIN_FRAME_EN
  assign oTxVld    = (state_q == S_SEND) || (state_q == S_PAD);
  assign oTxEof    = ((state_q == S_SEND) && last_byte && !pad_need) ||
                     ((state_q == S_PAD) && (cnt_q == MIN_LEN_M1));
`else
  assign oTxVld    = (state_q == S_SEND);
  assign oTxEof    = (state_q == S_SEND) && last_byte;
`endif

endmodule
